// File: rtl/aes_128_pkg.sv
// Shared constants and types for the AES-128 key expansion block.
package aes_128_pkg;

    localparam int unsigned KEY_W      = 128;
    localparam int unsigned NUM_ROUNDS = 10;

    // Indexed directly by the round counter; entry 0 and entries 11..15 are never used.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h00
    };

    typedef logic [KEY_W-1:0] round_key_t;
    typedef logic [31:0]      key_word_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

endpackage

// File: rtl/aes_128_key_expand_if.sv
// Key-load handshake and round-key read port of the key expansion block.
// key_zeroize exists only when AES_128_KEY_ZEROIZE_EN is defined.
interface aes_128_key_expand_if
    import aes_128_pkg::*;
#(
    parameter int unsigned NUM_KEY_SETS = 2
);

    logic                    key_valid;
    logic                    key_ready;
    logic                    key_set;
    round_key_t              key_data;
    logic [NUM_KEY_SETS-1:0] set_valid;
    logic                    rk_rd_en;
    logic                    rk_rd_set;
    logic [3:0]              rk_rd_round;
    round_key_t              rk_rd_data;
    logic                    rk_rd_vld;
`ifdef AES_128_KEY_ZEROIZE_EN
    logic                    key_zeroize;
`endif

    modport master (
`ifdef AES_128_KEY_ZEROIZE_EN
        output key_zeroize,
`endif
        output key_valid, key_set, key_data, rk_rd_en, rk_rd_set, rk_rd_round,
        input  key_ready, set_valid, rk_rd_data, rk_rd_vld
    );

    modport slave (
`ifdef AES_128_KEY_ZEROIZE_EN
        input  key_zeroize,
`endif
        input  key_valid, key_set, key_data, rk_rd_en, rk_rd_set, rk_rd_round,
        output key_ready, set_valid, rk_rd_data, rk_rd_vld
    );

endinterface

// File: rtl/aes_128_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_128_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the inverse of a and maps 0 to 0, exactly what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv   = gf_inv(in_i);
        out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_128_key_expand.sv
// AES-128 key expansion: one round key per cycle into per-set storage, registered read port.
// Build option AES_128_KEY_ZEROIZE_EN adds key_zeroize (clear storage, abort expansion).
module aes_128_key_expand
    import aes_128_pkg::*;
#(
    parameter int unsigned NUM_KEY_SETS = 2
) (
    input logic                 clk,
    input logic                 rst,
    aes_128_key_expand_if.slave bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t                  state_q, state_d;
    logic [3:0]              rcnt_q, rcnt_d;
    logic                    set_q, set_d;
    round_key_t              key_q, key_d;
    logic [NUM_KEY_SETS-1:0] set_valid_q, set_valid_d;
    round_key_t              rd_data_q, rd_data_d;
    logic                    rd_vld_q, rd_vld_d;
    round_key_t              store_q [NUM_KEY_SETS][NUM_ROUNDS+1];

    logic       zeroize, key_ready, accept, key_sel, rd_sel;
    logic       wr_en, wr_set;
    logic [3:0] wr_idx;
    round_key_t wr_data, next_rk;
    key_word_t  w0, w1, w2, w3, rot, sub, temp;

`ifdef AES_128_KEY_ZEROIZE_EN
    assign zeroize = bus.key_zeroize;
`else
    assign zeroize = 1'b0;
`endif

    assign key_sel   = (NUM_KEY_SETS > 1) ? bus.key_set : 1'b0;
    assign rd_sel    = (NUM_KEY_SETS > 1) ? bus.rk_rd_set : 1'b0;
    assign key_ready = (state_q == IDLE);
    assign accept    = bus.key_valid && key_ready && !zeroize;

    assign bus.key_ready  = key_ready;
    assign bus.set_valid  = set_valid_q;
    assign bus.rk_rd_data = rd_data_q;
    assign bus.rk_rd_vld  = rd_vld_q;

    // One round of the schedule, applied to the previous round key held in key_q.
    assign {w0, w1, w2, w3} = key_q;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_128_sbox u_sbox (
            .in_i  (rot[8*i +: 8]),
            .out_o (sub[8*i +: 8])
        );
    end

    assign temp    = sub ^ {RCON[rcnt_q], 24'h0};
    assign next_rk = {w0 ^ temp,
                      w1 ^ w0 ^ temp,
                      w2 ^ w1 ^ w0 ^ temp,
                      w3 ^ w2 ^ w1 ^ w0 ^ temp};

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        set_d       = set_q;
        key_d       = key_q;
        set_valid_d = set_valid_q;
        wr_en       = 1'b0;
        wr_set      = set_q;
        wr_idx      = rcnt_q;
        wr_data     = next_rk;
        if (zeroize) begin
            state_d     = IDLE;
            rcnt_d      = 4'd0;
            set_valid_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        wr_en                = 1'b1;
                        wr_set               = key_sel;
                        wr_idx               = 4'd0;
                        wr_data              = bus.key_data;
                        set_valid_d[key_sel] = 1'b0;
                        set_d                = key_sel;
                        key_d                = bus.key_data;
                        rcnt_d               = 4'd1;
                        state_d              = EXPAND;
                    end
                end
                EXPAND: begin
                    wr_en = 1'b1;
                    key_d = next_rk;
                    if (rcnt_q == LAST_ROUND) begin
                        set_valid_d[set_q] = 1'b1;
                        rcnt_d             = 4'd0;
                        state_d            = IDLE;
                    end else begin
                        rcnt_d = rcnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_vld_d  = 1'b0;
        rd_data_d = rd_data_q;
        if (zeroize) begin
            rd_data_d = '0;
        end else if (bus.rk_rd_en) begin
            rd_vld_d  = 1'b1;
            rd_data_d = (bus.rk_rd_round > LAST_ROUND) ? '0 : store_q[rd_sel][bus.rk_rd_round];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rcnt_q      <= 4'd0;
            set_q       <= 1'b0;
            key_q       <= '0;
            set_valid_q <= '0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            set_q       <= set_d;
            key_q       <= key_d;
            set_valid_q <= set_valid_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    // Storage is not reset; set_valid alone says whether a set is usable.
    always_ff @(posedge clk) begin
        if (zeroize) begin
            for (int s = 0; s < NUM_KEY_SETS; s++) begin
                for (int r = 0; r <= NUM_ROUNDS; r++) begin
                    store_q[s][r] <= '0;
                end
            end
        end else if (wr_en) begin
            store_q[wr_set][wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_aes_128_key_expand.sv
// Self-checking bench for aes_128_key_expand: known-answer table, randomized keys vs. a
// FIPS-197 word-schedule model, back-to-back loads, reset mid-expansion, optional zeroize.
module tb_aes_128_key_expand;
    import aes_128_pkg::*;

    typedef logic [10:0][127:0] rk_arr_t;

    typedef struct {
        round_key_t key;
        logic       set;
        logic [3:0] round;
        round_key_t exp;
    } vec_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    rk_arr_t    exp_rk [2];
    logic [1:0] exp_valid = 2'b00;
    round_key_t loaded [2];
    vec_t       vecs [6];

    aes_128_key_expand_if #(.NUM_KEY_SETS(2)) bus ();

    aes_128_key_expand #(.NUM_KEY_SETS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic key_word_t sub_word(input key_word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Textbook 44-word schedule, then grouped into 11 round keys.
    function automatic rk_arr_t expand(input round_key_t key);
        key_word_t  w [44];
        logic [7:0] rc;
        rk_arr_t    rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            if (i % 4 == 0) begin
                w[i] = w[i-4] ^ sub_word({w[i-1][23:0], w[i-1][31:24]}) ^ {rc, 24'h0};
                rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else begin
                w[i] = w[i-4] ^ w[i-1];
            end
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic round_key_t model_rd(input logic set, input logic [3:0] round);
        if (round > 4'd10) return '0;
        return exp_rk[set][round];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic rd(input logic set, input logic [3:0] round,
                      output round_key_t data, output logic vld);
        bus.rk_rd_en    = 1'b1;
        bus.rk_rd_set   = set;
        bus.rk_rd_round = round;
        @(posedge clk); #1;
        data = bus.rk_rd_data;
        vld  = bus.rk_rd_vld;
        bus.rk_rd_en = 1'b0;
    endtask

    // Loads a key and, while it expands, keeps reading the other set if that one is valid.
    task automatic load_key(input round_key_t key, input logic set);
        int   waited;
        int   lat;
        logic oth;
        oth    = ~set;
        waited = 0;
        while (bus.key_ready !== 1'b1 && waited < 30) begin
            @(posedge clk); #1;
            waited++;
        end
        if (bus.key_ready !== 1'b1) begin
            n_total++;
            $display("FAIL load_ready: key_ready %b, required 1 within 30 cycles", bus.key_ready);
            return;
        end
        bus.key_valid = 1'b1;
        bus.key_set   = set;
        bus.key_data  = key;
        @(posedge clk); #1;
        bus.key_valid  = 1'b0;
        exp_rk[set]    = expand(key);
        exp_valid[set] = 1'b0;
        loaded[set]    = key;
        check("accept_ready_low", bus.key_ready, 1'b0);
        check("accept_clears_valid", bus.set_valid[set], 1'b0);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            if (exp_valid[oth]) begin
                bus.rk_rd_en    = 1'b1;
                bus.rk_rd_set   = oth;
                bus.rk_rd_round = 4'((k - 1) % 11);
            end
            @(posedge clk); #1;
            if (exp_valid[oth]) begin
                check("other_set_read", bus.rk_rd_data, model_rd(oth, 4'((k - 1) % 11)));
                check("other_set_valid", bus.set_valid[oth], 1'b1);
            end
            bus.rk_rd_en = 1'b0;
            if (bus.set_valid[set] === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("set_valid_latency", lat, 10);
        check("ready_after_expand", bus.key_ready, 1'b1);
        exp_valid[set] = 1'b1;
    endtask

    initial begin
        round_key_t data, ka, kb;
        logic       vld;
        logic       s;
        logic [3:0] r;
        int         n_acc, low1, cnt;
        int         acc_c [2];

        bus.key_valid   = 1'b0;
        bus.key_set     = 1'b0;
        bus.key_data    = '0;
        bus.rk_rd_en    = 1'b0;
        bus.rk_rd_set   = 1'b0;
        bus.rk_rd_round = 4'd0;
`ifdef AES_128_KEY_ZEROIZE_EN
        bus.key_zeroize = 1'b0;
`endif
        loaded[0] = '0;
        loaded[1] = '0;

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 4'd0,
                    128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 4'd1,
                    128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 4'd10,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'd10,
                    128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[4] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'd0,
                    128'h000102030405060708090a0b0c0d0e0f};
        vecs[5] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'd11, 128'h0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_key_ready", bus.key_ready, 1'b1);
        check("rst_set_valid", bus.set_valid, 2'b00);
        check("rst_rd_data", bus.rk_rd_data, '0);
        check("rst_rd_vld", bus.rk_rd_vld, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer table; the set-1 load also reads set 0 throughout its expansion.
        for (int i = 0; i < 6; i++) begin
            if (!exp_valid[vecs[i].set] || loaded[vecs[i].set] !== vecs[i].key)
                load_key(vecs[i].key, vecs[i].set);
            rd(vecs[i].set, vecs[i].round, data, vld);
            check($sformatf("kat%0d_data", i), data, vecs[i].exp);
            check($sformatf("kat%0d_vld", i), vld, 1'b1);
        end

        // Out-of-range and idle reads.
        rd(1'b0, 4'd15, data, vld);
        check("rd_round15_data", data, '0);
        check("rd_round15_vld", vld, 1'b1);
        rd(1'b0, 4'd7, data, vld);
        check("rd_round7", data, model_rd(1'b0, 4'd7));
        @(posedge clk); #1;
        check("idle_rd_vld", bus.rk_rd_vld, 1'b0);
        check("idle_rd_hold", bus.rk_rd_data, model_rd(1'b0, 4'd7));

        // Back-to-back keys with key_valid held high.
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        n_acc = 0;
        low1  = 0;
        acc_c[0] = 0;
        acc_c[1] = 0;
        bus.key_valid = 1'b1;
        bus.key_set   = 1'b0;
        bus.key_data  = ka;
        for (int c = 0; c < 40; c++) begin
            if (n_acc == 1 && !bus.key_ready) low1++;
            if (bus.key_ready) begin
                acc_c[n_acc] = c;
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc == 1) begin
                bus.key_set  = 1'b1;
                bus.key_data = kb;
            end
            if (n_acc == 2) break;
        end
        bus.key_valid = 1'b0;
        cnt = 0;
        while (bus.set_valid !== 2'b11 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("b2b_accepts", n_acc, 2);
        check("b2b_spacing", acc_c[1] - acc_c[0], 11);
        check("b2b_ready_low", low1, 10);
        check("b2b_second_latency", cnt, 10);
        exp_rk[0] = expand(ka);
        exp_rk[1] = expand(kb);
        loaded[0] = ka;
        loaded[1] = kb;
        exp_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            rd(1'(i), 4'd10, data, vld);
            check($sformatf("b2b_set%0d_rk10", i), data, model_rd(1'(i), 4'd10));
        end

        // Reset in the 5th EXPAND cycle.
        bus.key_valid = 1'b1;
        bus.key_set   = 1'b0;
        bus.key_data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_set_valid", bus.set_valid, 2'b00);
        check("midrst_key_ready", bus.key_ready, 1'b1);
        check("midrst_rd_data", bus.rk_rd_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_valid = 2'b00;
        load_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        for (int i = 0; i <= 10; i += 2) begin
            rd(1'b1, 4'(i), data, vld);
            check($sformatf("postrst_rk%0d", i), data, model_rd(1'b1, 4'(i)));
        end

        // Randomized loads with random reads.
        for (int it = 0; it < 6; it++) begin
            s = 1'($urandom_range(0, 1));
            load_key({$urandom, $urandom, $urandom, $urandom}, s);
            for (int j = 0; j < 3; j++) begin
                r = 4'($urandom_range(0, 12));
                rd(s, r, data, vld);
                check($sformatf("rand%0d_set%0d_rk%0d", it, s, r), data, model_rd(s, r));
                check("rand_vld", vld, 1'b1);
            end
        end

`ifdef AES_128_KEY_ZEROIZE_EN
        if (!exp_valid[0]) load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        bus.key_valid = 1'b1;
        bus.key_set   = 1'b1;
        bus.key_data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.key_zeroize = 1'b1;
        bus.rk_rd_en    = 1'b1;
        bus.rk_rd_set   = 1'b0;
        bus.rk_rd_round = 4'd3;
        @(posedge clk); #1;
        bus.key_zeroize = 1'b0;
        bus.rk_rd_en    = 1'b0;
        exp_valid = 2'b00;
        check("zero_set_valid", bus.set_valid, 2'b00);
        check("zero_key_ready", bus.key_ready, 1'b1);
        check("zero_rd_vld", bus.rk_rd_vld, 1'b0);
        check("zero_rd_data", bus.rk_rd_data, '0);
        bus.key_zeroize = 1'b1;
        bus.key_valid   = 1'b1;
        @(posedge clk); #1;
        bus.key_zeroize = 1'b0;
        bus.key_valid   = 1'b0;
        check("zero_blocks_accept", bus.key_ready, 1'b1);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j <= 10; j++) begin
                rd(1'(i), 4'(j), data, vld);
                check($sformatf("zero_set%0d_rk%0d", i, j), data, '0);
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_128_key_expand.md
Name: aes_128_key_expand

Overview:
- Upstream stage of aes_128_top. Accepts 128-bit cipher keys over a valid/ready handshake and expands each into 11 round keys (RK0..RK10), one round per cycle.
- Stores the round keys in per-set key storage and serves them to the round datapath through a registered read port.
- Supports one key set (ONE_KEY build) or two key sets (TWO_KEY build).

Parameters:
- NUM_KEY_SETS, 2, number of independent key sets; legal values 1 or 2.
- KEY_W, 128, cipher key and round key width.
- NUM_ROUNDS, 10, number of expansion rounds; the block stores NUM_ROUNDS+1 round keys per set.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  a cipher key is offered.
- key_ready  out  1  the block can accept a key.
- key_set  in  1  target key set; ignored when NUM_KEY_SETS=1.
- key_data  in  128  cipher key; word0 = key_data[127:96] (FIPS-197 byte order).
- set_valid  out  NUM_KEY_SETS  per-set flag: all 11 round keys are stored.
- rk_rd_en  in  1  round-key read request.
- rk_rd_set  in  1  key set to read.
- rk_rd_round  in  4  round index to read, 0..10.
- rk_rd_data  out  128  round key, registered.
- rk_rd_vld  out  1  rk_rd_data is valid this cycle.
- key_zeroize  in  1  clears all key storage; present only with AES_128_KEY_ZEROIZE_EN.

Behaviour:
- Reset values: key_ready=1, set_valid=0, rk_rd_data=0, rk_rd_vld=0, FSM=IDLE, round counter=0. Key storage contents after reset are don't-care; set_valid=0 marks them unusable.
- FSM states: IDLE, EXPAND.
- IDLE:
  - key_ready=1.
  - On key_valid&&key_ready: RK0=key_data is written to the selected set. set_valid[set] clears on the same edge. The block latches set and key, sets rcnt=1, and moves to EXPAND.
- EXPAND:
  - key_ready=0.
  - Each cycle computes RK[rcnt] from RK[rcnt-1] and writes it:
    - temp = SubWord(RotWord(w3)) ^ {Rcon[rcnt],24'h0}
    - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
  - Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - When rcnt==10: RK10 is written, set_valid[set] sets on the same edge, and the FSM returns to IDLE.
- Latency: accept edge at cycle N; set_valid rises at edge N+10; key_ready returns high at edge N+10.
- Back-to-back keys: the next key is accepted in the first IDLE cycle, so accepts are 11 cycles apart.
- Rekeying a set that is already valid: the set is invalidated at accept. The other set stays valid and readable throughout.
- Read port:
  - rk_rd_en at edge N gives rk_rd_data/rk_rd_vld at edge N+1.
  - A read with rk_rd_round>10 returns 0, with rk_rd_vld=1.
  - A read is allowed during expansion, including of the set being expanded. Data for a round not yet written is stale; the consumer must gate on set_valid.
  - When rk_rd_en=0, rk_rd_vld=0 and rk_rd_data holds its previous value.
- NUM_KEY_SETS=1: key_set and rk_rd_set are ignored and treated as 0.
- Reset during EXPAND: the FSM returns to IDLE immediately, all set_valid bits clear, and the partial key is discarded.
- SubWord uses 4 parallel S-box instances. The path is combinational within one cycle.

Optional Feature:
- Macro: AES_128_KEY_ZEROIZE_EN.
- With the macro defined, key_zeroize=1 at an edge does all of the following on that edge:
  - Writes 0 to all storage.
  - Clears set_valid.
  - Aborts EXPAND and returns to IDLE.
  - Forces rk_rd_data=0 and rk_rd_vld=0.
  - Zeroize has priority over a simultaneous key accept; that key is not accepted.
- Without the macro: the port and logic are absent, and storage is cleared only by overwrite.

Decomposition:
- Package aes_128_pkg holds:
  - KEY_W, NUM_ROUNDS, the RCON constant array.
  - typedef round_key_t (logic [127:0]) and typedef key_word_t (logic [31:0]).
  - FSM enum state_t {IDLE, EXPAND}.
- One sub-module, aes_128_sbox: 8-bit combinational S-box lookup, instantiated 4 times for SubWord.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c to set 0 -> set_valid[0] rises 10 cycles after accept; RK1 = a0fafe1788542cb123a339392a6c7605; RK10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key 000102030405060708090a0b0c0d0e0f to set 1 while set 0 is valid -> RK10 of set 1 = 13111d7fe3944a17f307a78b4d2b30c5; set 0 reads stay unchanged throughout.
- Two keys offered back-to-back with key_valid held high -> key_ready low for 10 cycles after each accept; accepts exactly 11 cycles apart; both sets valid at the end.
- rst asserted at the 5th EXPAND cycle -> set_valid=00 and key_ready=1 immediately; a new key after reset expands correctly.
- Read with rk_rd_round=11 -> rk_rd_data=0 and rk_rd_vld=1 one cycle later; read with rk_rd_round=0 returns the raw key.
- AES_128_KEY_ZEROIZE_EN: key_zeroize mid-expansion -> set_valid=0, FSM in IDLE, all rounds read 0; a simultaneous key_valid is not accepted.
